pc_sequencer: RTL and testbench

Multi-cycle fetch/execute sequencer that owns the program counter and drives the `next_pc` mux. It holds PC, runs the instruction-memory fetch handshake, and presents the latched instruction to the decoder. In execute it turns decoder flags and the register-zero flag into `brzr_sel`/`jmp_sel`, then commits `next_pc` into PC. It sits between instruction memory, the decoder and `next_pc` in the REDUX-V core.

---
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/decode/execute sequencer for the REDUX-V core.
// Owns the program counter and runs the instruction-memory fetch handshake.
// It latches the fetched instruction for the decoder. In EXEC it drives the
// select lines of the external next_pc mux and commits the mux result into pc.
module pc_sequencer #(
    parameter int unsigned           BITS     = 8,
    parameter logic [BITS-1:0]       RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [BITS-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [BITS-1:0] imem_data,
    output logic [BITS-1:0] instr,
    output logic            decode,
    input  logic            is_jmp,
    input  logic            is_brzr,
    input  logic            is_halt,
    input  logic            reg_zero,
    input  logic            stall,
    output logic            brzr_sel,
    output logic            jmp_sel,
    output logic [BITS-1:0] pc_inc,
    input  logic [BITS-1:0] next_pc,
    output logic [BITS-1:0] pc,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t state;

    logic   in_exec;
    logic   conflict;

    // The fetch address is the program counter itself, so it cannot move
    // while FETCH waits for an ack.
    assign imem_addr = pc;

    // Sequential successor; wraps naturally at 2^BITS.
    assign pc_inc = pc + BITS'(1);

    // Select lines and the conflict pulse, live only while in EXEC.
    // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
    always_comb begin
        in_exec  = (state == S_EXEC);
        conflict = is_jmp & is_brzr;
        // Halt wins over both branch flags; a jmp+brzr conflict falls back
        // to pc_inc by leaving both selects low.
        jmp_sel  = in_exec & ~is_halt & is_jmp  & ~is_brzr;
        brzr_sel = in_exec & ~is_halt & is_brzr & ~is_jmp & reg_zero;
        // Pulses only on the cycle that actually commits the conflicting
        // instruction, not on the stalled cycles before it.
        illegal  = in_exec & ~stall & ~is_halt & conflict;
    end

    // Control FSM with registered outputs; also owns pc and the instruction latch.
    // NOTE: state and outputs use non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            instr    <= '0;
            imem_req <= 1'b0;
            decode   <= 1'b0;
            halted   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end

                S_FETCH: begin
                    // Request stays high until the ack edge; data is only
                    // captured on that edge.
                    if (imem_ack) begin
                        instr    <= imem_data;
                        imem_req <= 1'b0;
                        decode   <= 1'b1;
                        state    <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    decode <= 1'b0;
                    state  <= S_EXEC;
                end

                S_EXEC: begin
                    // A stalled EXEC holds everything; pc is written only on
                    // the committing edge.
                    if (!stall) begin
                        if (is_halt) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end

                S_HALT: begin
                    // Terminal until reset; start and acks are ignored.
                    halted <= 1'b1;
                end

                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                    decode   <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

    // Both selects high would present two sources to the next_pc mux.
    always_comb begin
        assert (!(jmp_sel && brzr_sel))
            else $error("pc_sequencer: jmp_sel and brzr_sel both asserted");
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer. A per-instruction timeline
// model produces the expected outputs for every cycle; a compare process
// checks them on the falling edge. Literal checks pin key addresses.
module tb_pc_sequencer;

    localparam int unsigned BITS   = 8;
    localparam logic [7:0]  RST_PC = 8'h00;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start     = 1'b0;
    logic       imem_ack  = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic       is_jmp    = 1'b0;
    logic       is_brzr   = 1'b0;
    logic       is_halt   = 1'b0;
    logic       reg_zero  = 1'b0;
    logic       stall     = 1'b0;
    logic [7:0] tgt       = 8'h00;

    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] instr;
    logic       decode;
    logic       brzr_sel;
    logic       jmp_sel;
    logic [7:0] pc_inc;
    logic [7:0] next_pc;
    logic [7:0] pc;
    logic       halted;
    logic       illegal;

    pc_sequencer #(
        .BITS     (BITS),
        .RESET_PC (RST_PC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .instr     (instr),
        .decode    (decode),
        .is_jmp    (is_jmp),
        .is_brzr   (is_brzr),
        .is_halt   (is_halt),
        .reg_zero  (reg_zero),
        .stall     (stall),
        .brzr_sel  (brzr_sel),
        .jmp_sel   (jmp_sel),
        .pc_inc    (pc_inc),
        .next_pc   (next_pc),
        .pc        (pc),
        .halted    (halted),
        .illegal   (illegal)
    );

    // External next_pc mux: branch/jump target or sequential successor.
    assign next_pc = (jmp_sel || brzr_sel) ? tgt : pc_inc;

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic [7:0] addr;
        logic [7:0] instr;
        logic       decode;
        logic       jmp;
        logic       brzr;
        logic       halted;
        logic       illegal;
        logic [7:0] pc;
        logic [7:0] pc_inc;
    } obs_t;

    int   checks    = 0;
    int   passed    = 0;
    int   cyc       = 0;
    obs_t exp       = '0;
    logic exp_valid = 1'b0;

    // Model state: architectural pc and latched instruction.
    logic [7:0] m_pc    = RST_PC;
    logic [7:0] m_instr = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.req     = imem_req;
        o.addr    = imem_addr;
        o.instr   = instr;
        o.decode  = decode;
        o.jmp     = jmp_sel;
        o.brzr    = brzr_sel;
        o.halted  = halted;
        o.illegal = illegal;
        o.pc      = pc;
        o.pc_inc  = pc_inc;
        return o;
    endfunction

    // Expected outputs when nothing but pc/instr is asserted.
    function automatic obs_t base();
        obs_t e = '0;
        e.addr   = m_pc;
        e.pc     = m_pc;
        e.instr  = m_instr;
        e.pc_inc = m_pc + 8'd1;
        return e;
    endfunction

    // Compare process: every meaningful cycle, away from the rising edge.
    always @(negedge clk) begin
        if (exp_valid) check($sformatf("cycle%0d", cyc), 64'(observe()), 64'(exp));
    end

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        start = 1'b0; imem_ack = 1'b0; stall = 1'b0;
        is_jmp = 1'b0; is_brzr = 1'b0; is_halt = 1'b0; reg_zero = 1'b0;
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        clear_inputs();
        rst_n = 1'b0;
        adv();
        adv();
        rst_n   = 1'b1;
        m_pc    = RST_PC;
        m_instr = 8'h00;
        exp       = base();
        exp_valid = 1'b1;
    endtask

    // Two IDLE cycles (ack ignored), start on the second; next cycle is FETCH.
    task automatic do_start();
        exp = base(); imem_ack = 1'b1; adv();
        start = 1'b1; exp = base(); adv();
        start = 1'b0; imem_ack = 1'b0;
    endtask

    // One instruction from its first FETCH cycle to the end of its EXEC.
    task automatic run_instr(input int ack_delay, input logic [7:0] data,
                             input logic j, input logic br, input logic h,
                             input logic rz, input int stalls,
                             input logic [7:0] target, input logic hold_start);
        obs_t e;
        start = hold_start;
        for (int k = 0; k <= ack_delay; k++) begin
            imem_ack  = (k == ack_delay);
            imem_data = (k == ack_delay) ? data : ~data;
            e = base(); e.req = 1'b1; exp = e; adv();
        end
        m_instr = data;
        // Ack and data during DECODE must be ignored.
        imem_ack = 1'b1; imem_data = 8'h5A;
        is_jmp = j; is_brzr = br; is_halt = h; reg_zero = rz; tgt = target;
        e = base(); e.decode = 1'b1; exp = e; adv();
        imem_ack = 1'b0;
        for (int s = 0; s <= stalls; s++) begin
            stall     = (s < stalls);
            e         = base();
            e.jmp     = !h && j && !br;
            e.brzr    = !h && br && !j && rz;
            e.illegal = !stall && !h && j && br;
            exp = e; adv();
        end
        if (!h) begin
            if ((j && !br) || (br && !j && rz)) m_pc = target;
            else m_pc = m_pc + 8'd1;
        end
        clear_inputs();
    endtask

    initial begin
        obs_t e;

        // Reset and sequential fetch with a two-cycle late ack.
        do_reset();
        do_start();
        run_instr(2, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0);
        run_instr(2, 8'h01, 0, 0, 0, 0, 0, 8'h00, 0);
        run_instr(2, 8'h02, 0, 0, 0, 0, 0, 8'h00, 0);
        check("seq_addr", 64'(imem_addr), 64'(8'h03));

        // Jumps: 0x03 -> 0x05 -> 0x40 (start held high throughout).
        run_instr(0, 8'hC5, 1, 0, 0, 0, 0, 8'h05, 1);
        check("pc_at_05", 64'(pc), 64'(8'h05));
        run_instr(1, 8'hC4, 1, 0, 0, 0, 0, 8'h40, 1);
        check("jmp_addr", 64'(imem_addr), 64'(8'h40));
        run_instr(0, 8'hC0, 1, 0, 0, 1, 0, 8'h10, 0);

        // Branch on zero taken, then not taken.
        run_instr(0, 8'hB1, 0, 1, 0, 1, 0, 8'h80, 0);
        check("brzr_taken", 64'(pc), 64'(8'h80));
        run_instr(0, 8'hC2, 1, 0, 0, 0, 0, 8'h10, 0);
        run_instr(0, 8'hB2, 0, 1, 0, 0, 0, 8'h80, 0);
        check("brzr_not_taken", 64'(pc), 64'(8'h11));

        // Conflict at 0xFF: selects forced low, pc wraps to 0x00.
        run_instr(0, 8'hC3, 1, 0, 0, 0, 0, 8'hFF, 0);
        run_instr(1, 8'hF0, 1, 1, 0, 1, 0, 8'h80, 0);
        check("conflict_wrap", 64'(pc), 64'(8'h00));

        // Three stalled EXEC cycles on a jump, then halt with jmp also set.
        run_instr(0, 8'hC6, 1, 0, 0, 0, 3, 8'h20, 1);
        check("stall_jmp", 64'(pc), 64'(8'h20));
        run_instr(0, 8'hEE, 1, 0, 1, 0, 1, 8'h99, 0);
        for (int i = 0; i < 4; i++) begin
            start    = (i == 1);
            imem_ack = (i == 2);
            e = base(); e.halted = 1'b1; exp = e; adv();
        end
        clear_inputs();
        check("halt_pc", 64'(pc), 64'(8'h20));
        check("halt_req", 64'(imem_req), 64'(1'b0));

        // Reset asynchronously in the middle of FETCH at pc 0x33.
        do_reset();
        do_start();
        run_instr(0, 8'hC7, 1, 0, 0, 0, 0, 8'h33, 0);
        e = base(); e.req = 1'b1; exp = e;
        #2;
        exp_valid = 1'b0;
        check("fetch_req_pre", 64'(imem_req), 64'(1'b1));
        rst_n = 1'b0;
        #1;
        check("async_pc_fetch", 64'(pc), 64'(RST_PC));
        check("async_req_fetch", 64'(imem_req), 64'(1'b0));
        check("async_instr_fetch", 64'(instr), 64'(8'h00));
        do_reset();

        // Reset asynchronously in EXEC with a jump to 0x77 pending.
        do_start();
        imem_ack = 1'b1; imem_data = 8'hC8;
        m_instr = 8'h00; e = base(); e.req = 1'b1; exp = e; adv();
        m_instr = 8'hC8; imem_ack = 1'b0; is_jmp = 1'b1; tgt = 8'h77;
        e = base(); e.decode = 1'b1; exp = e; adv();
        e = base(); e.jmp = 1'b1; exp = e;
        #2;
        exp_valid = 1'b0;
        check("exec_jmp_pre", 64'(jmp_sel), 64'(1'b1));
        rst_n = 1'b0;
        #1;
        check("async_jmp_exec", 64'(jmp_sel), 64'(1'b0));
        check("async_pc_exec", 64'(pc), 64'(RST_PC));
        adv();
        check("no_pending_write", 64'(pc), 64'(RST_PC));
        do_reset();

        // Normal operation resumes after reset.
        do_start();
        run_instr(0, 8'h01, 0, 0, 0, 0, 0, 8'h00, 0);
        check("resume_pc", 64'(pc), 64'(8'h01));
        exp_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Time bound so the run cannot hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
